// File: rtl/hmux_arb_nway_if.sv
// Channel bundle for hmux_arb_nway: N producer channels in, one registered
// valid/ready word out, plus the software force controls.
interface hmux_arb_nway_if #(
  parameter int N = 4,
  parameter int W = 16
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           force_en;
  logic [SW-1:0]  force_sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;

  // Mux side
  modport slave (
    input  in_data, in_valid, force_en, force_sel, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  // Producer/consumer side
  modport master (
    output in_data, in_valid, force_en, force_sel, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/hmux_arb_nway.sv
// N-way W-bit handshaked mux: forced, fixed-priority or round-robin selection
// of one producer channel into a single registered valid/ready output stage.
module hmux_arb_nway #(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int RR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  hmux_arb_nway_if.slave   bus
);
  localparam int SW = $clog2(N);

  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_sel;
  logic          r_out_valid;
  logic [SW-1:0] r_rr_ptr;

  logic [W-1:0]  w_chan [N];
  logic [N-1:0]  w_elig;
  logic [SW-1:0] w_grant;
  logic          w_any;
  logic          w_load_en;
  logic          w_xfer;

  // Forcing makes only force_sel eligible; an out-of-range index matches nothing.
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign w_chan[gi] = bus.in_data[gi*W +: W];
    assign w_elig[gi] = bus.force_en ? (bus.force_sel == SW'(gi)) : bus.in_valid[gi];
  end

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign w_load_en = rst_n & (~r_out_valid | bus.out_ready);

  // Scan from the far end so the closest eligible index is the last one written.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_any   = 1'b0;
    if (RR != 0) begin
      for (int k = N; k >= 1; k--) begin
        idx = (int'(r_rr_ptr) + k) % N;
        if (w_elig[idx]) begin
          w_grant = SW'(idx);
          w_any   = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (w_elig[i]) begin
          w_grant = SW'(i);
          w_any   = 1'b1;
        end
      end
    end
  end

  assign w_xfer = w_load_en & w_any & bus.in_valid[w_grant];

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign bus.in_ready[gi] = w_xfer & (w_grant == SW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= SW'(N - 1);
    end else if (w_xfer) begin
      r_out_data  <= w_chan[w_grant];
      r_out_sel   <= w_grant;
      r_out_valid <= 1'b1;
      // Forced transfers leave the round-robin position untouched.
      if (RR != 0 && !bus.force_en) begin
        r_rr_ptr <= w_grant;
      end
    end else if (w_load_en && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;
  assign bus.out_valid = r_out_valid;
endmodule

// File: doc/hmux_arb_nway.md
Name: hmux_arb_nway

Overview:
- Parametrised, handshaked successor to the 4-way 16-bit mux: selects one of N W-bit channels and delivers it through a registered valid/ready output stage.
- Selection is either software-forced (classic sel-driven mux behaviour) or arbitrated: fixed-priority or round-robin.
- Sits between multiple producers (ALU/RAM/IO result paths) and a single consumer bus in the Hack datapath.

Parameters:
- N, 4, number of input channels (2..16).
- W, 16, data width per channel.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SW (localparam), clog2(N), width of select/grant fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  N*W  packed channel data; channel i at bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; one-hot or zero.
- force_en  in  1  1 = only channel force_sel is eligible.
- force_sel  in  SW  forced channel index.
- out_data  out  W  registered selected data.
- out_sel  out  SW  index of the channel held in out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_sel=0, rr_ptr=N-1 (so channel 0 has first priority); in_ready=0 while in reset.
- load_en = !out_valid || out_ready (combinational).
- Eligible set E: if force_en, E = {force_sel} when force_sel < N, else empty; otherwise E = {i | in_valid[i]}.
- Grant g (combinational):
  - RR=1: first eligible index searching rr_ptr+1, rr_ptr+2, ... mod N.
  - RR=0: lowest eligible index.
  - force_en: g = force_sel, only if in_valid[force_sel].
- in_ready[i] = load_en && E nonempty && in_valid[g] && i==g. At most one bit is set. No combinational path from in_valid[i] to in_ready[j≠i] other than via grant.
- Transfer on channel g when in_valid[g] && in_ready[g]. On that edge:
  - out_data <= in_data[g*W +: W]; out_sel <= g; out_valid <= 1.
  - if RR=1 and force_en=0: rr_ptr <= g.
- If load_en and no transfer: out_valid <= 0 when out_ready; out_data and out_sel hold their last values.
- If out_valid && !out_ready: out_data, out_sel and out_valid are held stable; all in_ready=0.
- Latency: 1 cycle from accepted input to out_valid. Throughput: 1 word/cycle with out_ready held at 1 (simultaneous consume and load in the same cycle).
- Forced transfers do not move rr_ptr; arbitration resumes from the prior pointer when force_en drops.
- force_sel >= N: no channel eligible; output drains normally.
- force_en or force_sel changing while output is stalled: takes effect only at the next load_en cycle; the held word is unaffected.
- Reset asserted mid-transfer: the word is discarded and all state returns to reset values immediately (asynchronous).
- W and N changes require no RTL edits; all indexing is parametric.

Test Plan:
- Reset, then N=4, W=16, RR=1, out_ready=1; in_data = {16'h0003, 16'h0002, 16'h0001, 16'h0000}; all in_valid=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; out_data equals out_sel; out_valid=1 from the first load edge onward.
- RR=0 with the same stimulus -> out_sel=0 every cycle; in_ready=4'b0001 constantly.
- force_en=1, force_sel=2, all valid, sel swept 0→3 each 2 cycles (as in the original mux bench) -> out_data follows 0,1,2,3; rr_ptr unchanged (after force_en=0, next grant is rr_ptr+1).
- Backpressure: load 16'h0002, hold out_ready=0 for 5 cycles with channels still valid -> out_data=16'h0002 and out_valid=1 stable; in_ready=0; releasing out_ready transfers the next RR channel the same cycle.
- Sparse valid: in_valid=4'b1000 only, rr_ptr=3 -> channel 3 still granted (wrap-around); in_valid=0 with out_ready=1 -> out_valid drops after one cycle.
- Assert rst_n=0 between clock edges while out_valid=1 -> out_valid=0 and out_data=0 immediately; after release, the first grant goes to channel 0.
